prog_loader: RTL and testbench

Boot-time program loader that writes the program memory the pipelined core fetches from. It accepts a framed byte stream on a valid/ready interface and assembles 17-bit instruction words from three bytes each. It writes those words into program memory at consecutive 8-bit addresses and holds the core stalled until a checksum-verified image is complete.

---
 rtl/prog_loader_if.sv | 32 +++
 rtl/prog_loader.sv | 132 +++++++++++++
 tb/tb_prog_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream, program-memory write and status signals of the boot loader.
// Latency: none, wiring only.
// Backpressure: rx_ready from the loader gates rx_valid/rx_data from the host.
interface prog_loader_if #(
    parameter int IW = 17,
    parameter int AW = 8
);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          pm_we;
    logic [AW-1:0] pm_addr;
    logic [IW-1:0] pm_wdata;
    logic          core_hold;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    // Host side: supplies bytes, observes memory writes and status.
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, pm_we, pm_addr, pm_wdata,
        input  core_hold, done, error, words_loaded
    );

    // Loader side.
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, pm_we, pm_addr, pm_wdata,
        output core_hold, done, error, words_loaded
    );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader: assembles 3-byte words into program memory, verifies checksum, releases core.
// Latency: pm_we one cycle after the last byte of a word; done one cycle after a matching checksum byte.
// Backpressure: rx_ready is high in every state but DONE, so one byte per cycle is sustained.
module prog_loader #(
    parameter int DEPTH = 256,
    parameter int IW    = 17,
    parameter int AW    = 8
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, COUNT, B0, B1, B2, CHECK, DONE, ERR
    } state_t;

    localparam logic [7:0]  HDR   = 8'hA5;
    localparam logic [AW:0] ONE   = (AW+1)'(1);
    localparam logic [AW:0] N_MAX = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   words_q, words_d;
    logic [7:0]    sum_q, sum_d;
    logic          hi_q, hi_d;
    logic [7:0]    mid_q, mid_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] wdata_q, wdata_d;
    logic          accept;

    assign bus.rx_ready     = (state_q != DONE);
    assign accept           = bus.rx_valid && bus.rx_ready;
    assign bus.pm_we        = we_q;
    assign bus.pm_addr      = addr_q;
    assign bus.pm_wdata     = wdata_q;
    assign bus.core_hold    = (state_q != DONE);
    assign bus.done         = (state_q == DONE);
    assign bus.error        = (state_q == ERR);
    assign bus.words_loaded = words_q;

    // State and datapath registers; partial memory writes survive reset, the loader does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            words_q <= '0;
            sum_q   <= '0;
            hi_q    <= 1'b0;
            mid_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            words_q <= words_d;
            sum_q   <= sum_d;
            hi_q    <= hi_d;
            mid_q   <= mid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Frame parser: next state, running checksum, word assembly and write scheduling.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        words_d = words_q;
        sum_d   = sum_q;
        hi_d    = hi_q;
        mid_d   = mid_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        // The count advances on the edge that ends the write cycle; words are
        // at least three bytes apart, so this never races with a new B2 byte.
        if (we_q) begin
            words_d = words_q + ONE;
        end

        if (accept) begin
            case (state_q)
                IDLE, ERR: begin
                    if (bus.rx_data == HDR) begin
                        state_d = COUNT;
                        sum_d   = '0;
                        words_d = '0;
                    end
                end
                COUNT: begin
                    count_d = (bus.rx_data == 8'h00) ? N_MAX : {1'b0, bus.rx_data};
                    sum_d   = bus.rx_data;
                    state_d = B0;
                end
                B0: begin
                    if (bus.rx_data[7:1] != 7'd0) begin
                        state_d = ERR;
                    end else begin
                        hi_d    = bus.rx_data[0];
                        sum_d   = sum_q + bus.rx_data;
                        state_d = B1;
                    end
                end
                B1: begin
                    mid_d   = bus.rx_data;
                    sum_d   = sum_q + bus.rx_data;
                    state_d = B2;
                end
                B2: begin
                    sum_d   = sum_q + bus.rx_data;
                    we_d    = 1'b1;
                    addr_d  = words_q[AW-1:0];
                    wdata_d = IW'({hi_q, mid_q, bus.rx_data});
                    state_d = ((words_q + ONE) == count_q) ? CHECK : B0;
                end
                CHECK: begin
                    state_d = (bus.rx_data == sum_q) ? DONE : ERR;
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected writes queued at stimulus time, popped by a write monitor.
// Latency: status outputs checked one cycle after the relevant byte is accepted.
// Backpressure: byte sender waits (bounded) on rx_ready before each transfer.
module tb_prog_loader;
    logic clk;
    logic reset;

    prog_loader_if #(.IW(17), .AW(8)) bus ();

    prog_loader #(.DEPTH(256), .IW(17), .AW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [16:0] data;
    } wr_t;

    wr_t        exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] csum;
    int         gap      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every pm_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.pm_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_we: addr 0x%0h data 0x%0h with no write expected at %0t",
                         bus.pm_addr, bus.pm_wdata, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("pm_addr", 32'(bus.pm_addr), 32'(e.addr));
                chk("pm_wdata", 32'(bus.pm_wdata), 32'(e.data));
            end
        end
    end

    // One byte transfer: driven at negedge, transfers on the next posedge with rx_ready.
    task automatic send(input logic [7:0] b);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL rx_ready_timeout: rx_ready stayed low for %0d cycles, byte 0x%0h", n, b);
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    // Checksummed byte (count or payload).
    task automatic send_pl(input logic [7:0] b);
        csum = csum + b;
        send(b);
    endtask

    task automatic send_word(input logic [7:0] a, input logic [16:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        send_pl({7'd0, d[16]});
        send_pl(d[15:8]);
        send_pl(d[7:0]);
    endtask

    task automatic start_frame(input logic [7:0] n);
        send(8'hA5);
        csum = 8'h00;
        send_pl(n);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rx_ready"},  32'(bus.rx_ready),     32'd1);
        chk({tag, "_pm_we"},     32'(bus.pm_we),        32'd0);
        chk({tag, "_pm_addr"},   32'(bus.pm_addr),      32'd0);
        chk({tag, "_pm_wdata"},  32'(bus.pm_wdata),     32'd0);
        chk({tag, "_core_hold"}, 32'(bus.core_hold),    32'd1);
        chk({tag, "_done"},      32'(bus.done),         32'd0);
        chk({tag, "_error"},     32'(bus.error),        32'd0);
        chk({tag, "_words"},     32'(bus.words_loaded), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        csum         = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b0;

        // Two-word image with correct checksum.
        start_frame(8'd2);
        send_word(8'd0, 17'h12345);
        send_word(8'd1, 17'h06789);
        chk("t1_done_before_cksum", 32'(bus.done), 32'd0);
        chk("t1_hold_before_cksum", 32'(bus.core_hold), 32'd1);
        send(csum);
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_core_hold", 32'(bus.core_hold), 32'd0);
        chk("t1_words", 32'(bus.words_loaded), 32'd2);
        chk("t1_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("t1_error", 32'(bus.error), 32'd0);

        // Same image, wrong checksum, then recovery with a good frame.
        do_reset();
        start_frame(8'd2);
        send_word(8'd0, 17'h12345);
        send_word(8'd1, 17'h06789);
        send(csum - 8'd1);
        chk("t2_error", 32'(bus.error), 32'd1);
        chk("t2_core_hold", 32'(bus.core_hold), 32'd1);
        chk("t2_done", 32'(bus.done), 32'd0);
        chk("t2_words", 32'(bus.words_loaded), 32'd2);
        send(8'h33);
        chk("t2_error_sticky", 32'(bus.error), 32'd1);
        start_frame(8'd2);
        chk("t2_error_cleared", 32'(bus.error), 32'd0);
        chk("t2_words_cleared", 32'(bus.words_loaded), 32'd0);
        send_word(8'd0, 17'h12345);
        send_word(8'd1, 17'h06789);
        send(csum);
        chk("t2_done", 32'(bus.done), 32'd1);
        chk("t2_error_after", 32'(bus.error), 32'd0);

        // Leading garbage ignored, gaps between bytes.
        do_reset();
        gap = 2;
        send(8'hFF);
        send(8'h00);
        start_frame(8'd1);
        send_word(8'd0, 17'h00001);
        chk("t3_csum_value", 32'(csum), 32'h02);
        send(csum);
        gap = 0;
        chk("t3_done", 32'(bus.done), 32'd1);
        chk("t3_words", 32'(bus.words_loaded), 32'd1);

        // Bad byte0 reserved bits.
        do_reset();
        send(8'hA5);
        send(8'h01);
        send(8'h02);
        chk("t4_error", 32'(bus.error), 32'd1);
        chk("t4_core_hold", 32'(bus.core_hold), 32'd1);
        send(8'h00);
        send(8'h00);
        chk("t4_error_sticky", 32'(bus.error), 32'd1);
        chk("t4_words", 32'(bus.words_loaded), 32'd0);

        // Full 256-word image (count byte 0).
        do_reset();
        start_frame(8'd0);
        for (int i = 0; i < 256; i++) begin
            send_word(8'(i), 17'(i));
        end
        chk("t5_csum_value", 32'(csum), 32'h80);
        send(csum);
        chk("t5_done", 32'(bus.done), 32'd1);
        chk("t5_words", 32'(bus.words_loaded), 32'd256);

        // Reset mid-frame after the second payload byte.
        do_reset();
        send(8'hA5);
        send(8'h01);
        send(8'h01);
        send(8'h23);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("t6_rst");
        reset = 1'b0;
        start_frame(8'd1);
        send_word(8'd0, 17'h1FFFF);
        send(csum);
        chk("t6_done", 32'(bus.done), 32'd1);
        chk("t6_words", 32'(bus.words_loaded), 32'd1);

        repeat (4) @(posedge clk);
        #1;
        chk("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
